// File: rtl/ic232_pkg.sv
// ic232_pkg: shared definitions for the ic232 sequencer slice.
//   state_e          sequencer FSM states (IDLE, RUN, CAPT, DONE)
//   PAT_W            width of the {A2,A1,A0} drive pattern
//   A0_IDX..A2_IDX   bit positions of each ic232 input within the pattern
package ic232_pkg;

  localparam int PAT_W  = 3;
  localparam int A0_IDX = 0;
  localparam int A1_IDX = 1;
  localparam int A2_IDX = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: width-parameterised up-counter that sticks at all-ones.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        load zero (takes priority over inc_i)
//   inc_i        add one unless already saturated
//   count_o      registered count
//   next_o       value count_o takes at the next edge, so a caller can
//                capture "count including this cycle's increment"
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/ic232_sequencer.sv
// ic232_sequencer: applies a 3-bit pattern to one ic232 for N clock edges,
// counts edges after which Z was high, and reports the final {Q1,Q0}.
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_pattern           {A2,A1,A0} to apply
//   cmd_cycles            N, number of ic232 edges to apply the pattern
//   abort                 early termination while RUN or CAPT
//   A0, A1, A2            registered drive to ic232
//   Q0, Q1, Z             ic232 outputs
//   busy                  high in RUN and CAPT
//   done                  one-cycle pulse, rsp_* valid with it
//   rsp_z_count           Z-high count (saturating)
//   rsp_q                 {Q1,Q0} after the last applied edge
//   rsp_aborted           command ended by abort
//   dbg_state             current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is 1 only in IDLE, and cmd_* are ignored
// otherwise. No backpressure exists on the response side: done is a pulse.
module ic232_sequencer
  import ic232_pkg::*;
#(
  parameter int               CNT_W   = 8,
  parameter int               ZCNT_W  = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PAT_W-1:0]  cmd_pattern,
  input  logic [CNT_W-1:0]  cmd_cycles,
  input  logic              abort,
  output logic              A0,
  output logic              A1,
  output logic              A2,
  input  logic              Q0,
  input  logic              Q1,
  input  logic              Z,
  output logic              busy,
  output logic              done,
  output logic [ZCNT_W-1:0] rsp_z_count,
  output logic [1:0]        rsp_q,
  output logic              rsp_aborted,
  output state_e            dbg_state
);

  state_e              state_q;
  logic [PAT_W-1:0]    a_q;
  logic [CNT_W-1:0]    rem_q;
  logic                first_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                done_q;
  logic [ZCNT_W-1:0]   rsp_z_count_q;
  logic [1:0]          rsp_q_q;
  logic                rsp_aborted_q;

  logic                accept;
  logic                zc_clr;
  logic                zc_inc;
  logic [ZCNT_W-1:0]   zc_count;
  logic [ZCNT_W-1:0]   zc_next;

  assign accept = (state_q == IDLE) && cmd_valid;

  // The first RUN edge is the one on which ic232 first sees the new pattern,
  // so Z at that edge still reflects the previous command and is skipped.
  assign zc_clr = accept;
  assign zc_inc = Z && (((state_q == RUN) && !first_q) || (state_q == CAPT));

  sat_counter #(.W(ZCNT_W)) u_zc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (zc_clr),
    .inc_i   (zc_inc),
    .count_o (zc_count),
    .next_o  (zc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= RST_PAT;
      rem_q         <= '0;
      first_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rsp_z_count_q <= '0;
      rsp_q_q       <= 2'b00;
      rsp_aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q         <= cmd_pattern;
            rem_q       <= cmd_cycles;
            first_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            if (cmd_cycles == '0) begin
              // Nothing to apply: report the ic232 state as seen right now.
              state_q       <= DONE;
              done_q        <= 1'b1;
              rsp_q_q       <= {Q1, Q0};
              rsp_z_count_q <= '0;
              rsp_aborted_q <= 1'b0;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_q - CNT_W'(1);
          first_q <= 1'b0;
          if (abort) begin
            state_q       <= DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            rsp_q_q       <= {Q1, Q0};
            rsp_z_count_q <= zc_next;
            rsp_aborted_q <= 1'b1;
          end else if (rem_q == CNT_W'(1)) begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
          // zc_next already folds in Z after the final applied edge.
          state_q       <= DONE;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          rsp_q_q       <= {Q1, Q0};
          rsp_z_count_q <= zc_next;
          rsp_aborted_q <= abort;
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign A0          = a_q[A0_IDX];
  assign A1          = a_q[A1_IDX];
  assign A2          = a_q[A2_IDX];
  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rsp_z_count = rsp_z_count_q;
  assign rsp_q       = rsp_q_q;
  assign rsp_aborted = rsp_aborted_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ic232_sequencer.sv
// Directed testbench for ic232_sequencer with a small behavioural ic232:
//   A1=1 hold, else A0=1 toggle Q0, else A2=1 load 10, else load 00;
//   Z = 1 when Q1 == Q0.
module tb_ic232_sequencer;
  import ic232_pkg::*;

  localparam int CNT_W  = 8;
  localparam int ZCNT_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_pattern = 3'b000;
  logic [CNT_W-1:0]  cmd_cycles = '0;
  logic              abort = 1'b0;
  logic              A0, A1, A2;
  logic              Q0, Q1, Z;
  logic              busy;
  logic              done;
  logic [ZCNT_W-1:0] rsp_z_count;
  logic [1:0]        rsp_q;
  logic              rsp_aborted;
  state_e            dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ic232 model ----------------
  logic [1:0] m_q = 2'b00;
  always @(posedge clk) begin
    if (A1)      m_q <= m_q;
    else if (A0) m_q <= {m_q[1], ~m_q[0]};
    else if (A2) m_q <= 2'b10;
    else         m_q <= 2'b00;
  end
  assign Q1 = m_q[1];
  assign Q0 = m_q[0];
  assign Z  = ~(m_q[1] ^ m_q[0]);

  ic232_sequencer #(.CNT_W(CNT_W), .ZCNT_W(ZCNT_W), .RST_PAT(3'b000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .cmd_cycles(cmd_cycles),
    .abort(abort),
    .A0(A0), .A1(A1), .A2(A2),
    .Q0(Q0), .Q1(Q1), .Z(Z),
    .busy(busy), .done(done),
    .rsp_z_count(rsp_z_count), .rsp_q(rsp_q), .rsp_aborted(rsp_aborted),
    .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Returns at the falling edge after the accept edge.
  task automatic send_cmd(input logic [2:0] pat, input logic [CNT_W-1:0] n);
    int g;
    g = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    cmd_valid   = 1'b1;
    cmd_pattern = pat;
    cmd_cycles  = n;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts edges from accept (=1) to the edge that raised done.
  task automatic wait_done(output int lat, output logic saw_busy);
    lat = 1;
    saw_busy = busy;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      saw_busy = saw_busy | busy;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({A2, A1, A0} !== 3'b000) begin errors++; $display("FAIL reset_a got=%b exp=000", {A2, A1, A0}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (rsp_z_count !== '0 || rsp_q !== 2'b00 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got z=%0d q=%b ab=%b exp 0/00/0", rsp_z_count, rsp_q, rsp_aborted); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    int lat; logic sb;
    send_cmd(3'b100, 8'd1);
    wait_done(lat, sb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_lat got=%0d exp=3", lat); end
    checks++; if (rsp_q !== 2'b10 || rsp_z_count !== 2'd0 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL load_rsp got q=%b z=%0d ab=%b exp 10/0/0", rsp_q, rsp_z_count, rsp_aborted); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL load_pulse got done=%b ready=%b exp 0/1", done, cmd_ready); end
  endtask

  task automatic test_hold();
    int lat; logic sb;
    send_cmd(3'b010, 8'd3);
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_busy got busy=%b ready=%b exp 1/0", busy, cmd_ready); end
    checks++; if ({A2, A1, A0} !== 3'b010) begin errors++; $display("FAIL hold_drive got=%b exp=010", {A2, A1, A0}); end
    wait_done(lat, sb);
    checks++; if (lat !== 5) begin errors++; $display("FAIL hold_lat got=%0d exp=5", lat); end
    checks++; if (rsp_q !== 2'b10 || rsp_z_count !== 2'd0 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL hold_rsp got q=%b z=%0d ab=%b exp 10/0/0", rsp_q, rsp_z_count, rsp_aborted); end
  endtask

  task automatic test_zero();
    int lat; logic sb;
    send_cmd(3'b010, 8'd0);
    wait_done(lat, sb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_lat got=%0d exp=1", lat); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", sb); end
    checks++; if (rsp_q !== 2'b10 || rsp_z_count !== 2'd0 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL zero_rsp got q=%b z=%0d ab=%b exp 10/0/0", rsp_q, rsp_z_count, rsp_aborted); end
  endtask

  task automatic test_toggle();
    int lat; logic sb;
    send_cmd(3'b001, 8'd4);
    wait_done(lat, sb);
    checks++; if (lat !== 6) begin errors++; $display("FAIL toggle_lat got=%0d exp=6", lat); end
    checks++; if (rsp_q !== 2'b10 || rsp_z_count !== 2'd2 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL toggle_rsp got q=%b z=%0d ab=%b exp 10/2/0", rsp_q, rsp_z_count, rsp_aborted); end
  endtask

  task automatic test_clear();
    int lat; logic sb;
    send_cmd(3'b000, 8'd1);
    wait_done(lat, sb);
    checks++; if (rsp_q !== 2'b00 || rsp_z_count !== 2'd1 || lat !== 3) begin
      errors++; $display("FAIL clear_rsp got q=%b z=%0d lat=%0d exp 00/1/3", rsp_q, rsp_z_count, lat); end
  endtask

  task automatic test_saturation();
    int lat; logic sb;
    send_cmd(3'b011, 8'd6);
    wait_done(lat, sb);
    checks++; if (lat !== 8) begin errors++; $display("FAIL sat_lat got=%0d exp=8", lat); end
    checks++; if (rsp_q !== 2'b00 || rsp_z_count !== 2'd3 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL sat_rsp got q=%b z=%0d ab=%b exp 00/3/0", rsp_q, rsp_z_count, rsp_aborted); end
  endtask

  task automatic test_abort();
    int lat; logic sb;
    send_cmd(3'b010, 8'd10);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || dbg_state !== DONE) begin errors++; $display("FAIL abort_done got done=%b st=%0d exp 1/%0d", done, dbg_state, DONE); end
    checks++; if (rsp_aborted !== 1'b1 || rsp_z_count !== 2'd2 || rsp_q !== 2'b00) begin
      errors++; $display("FAIL abort_rsp got ab=%b z=%0d q=%b exp 1/2/00", rsp_aborted, rsp_z_count, rsp_q); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_ready got ready=%b done=%b exp 1/0", cmd_ready, done); end
    send_cmd(3'b100, 8'd1);
    wait_done(lat, sb);
    checks++; if (lat !== 3 || rsp_aborted !== 1'b0 || rsp_q !== 2'b10 || rsp_z_count !== 2'd0) begin
      errors++; $display("FAIL abort_next got lat=%0d ab=%b q=%b z=%0d exp 3/0/10/0", lat, rsp_aborted, rsp_q, rsp_z_count); end
  endtask

  task automatic test_idle_abort();
    int lat; logic sb;
    abort = 1'b1;
    send_cmd(3'b010, 8'd2);
    abort = 1'b0;
    wait_done(lat, sb);
    checks++; if (lat !== 4 || rsp_aborted !== 1'b0 || rsp_q !== 2'b10 || rsp_z_count !== 2'd0) begin
      errors++; $display("FAIL idle_abort got lat=%0d ab=%b q=%b z=%0d exp 4/0/10/0", lat, rsp_aborted, rsp_q, rsp_z_count); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    send_cmd(3'b100, 8'd10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({A2, A1, A0} !== 3'b000 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got a=%b ready=%b busy=%b done=%b exp 000/1/0/0", {A2, A1, A0}, cmd_ready, busy, done); end
    checks++; if (rsp_z_count !== '0 || rsp_q !== 2'b00 || rsp_aborted !== 1'b0) begin
      errors++; $display("FAIL midrst_rsp got z=%0d q=%b ab=%b exp 0/00/0", rsp_z_count, rsp_q, rsp_aborted); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    checks++; if (saw_done !== 1'b0 || dbg_state !== IDLE || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_after got done_seen=%b st=%0d ready=%b exp 0/%0d/1", saw_done, dbg_state, cmd_ready, IDLE); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_zero();
    test_toggle();
    test_clear();
    test_saturation();
    test_abort();
    test_idle_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
